// File: rtl/binary_up_counter4_pkg.sv
// Shared constants and types for the loadable binary up-counter.
// No logic lives here; the counter top imports it for its default width.
// Kept separate so other blocks can size buses against the same default.
package binary_up_counter4_pkg;

  // Default counter and load-data width in bits.
  localparam int COUNTER_W_DEFAULT = 4;

  // Counter value at the default width.
  typedef logic [COUNTER_W_DEFAULT-1:0] count_t;

endpackage : binary_up_counter4_pkg

// File: rtl/binary_up_counter4.sv
// Loadable free-running binary up-counter, wraps modulo 2^WIDTH.
// Latency: reset/load/increment visible right after the sampling clk edge.
// No backpressure: counts on every edge that has neither reset nor load.
module binary_up_counter4
  import binary_up_counter4_pkg::*;
#(
  parameter int WIDTH = COUNTER_W_DEFAULT
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  // State register: reset beats load, load beats increment; all-ones rolls to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= data_in;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

`ifndef SYNTHESIS
  // Marks that a reset edge has been seen, so checks ignore the undefined start-up value.
  logic past_valid;
  always_ff @(posedge clk) begin
    if (reset) begin
      past_valid <= 1'b1;
    end
  end

  // Reset wins over everything, including a simultaneous load.
  a_reset_priority : assert property (@(posedge clk)
    reset |=> (count == '0));

  // A load without reset takes the preload value verbatim.
  a_load_value : assert property (@(posedge clk)
    (!reset && load) |=> (count == $past(data_in)));

  // An idle edge after reset advances the count by exactly one.
  a_step_one : assert property (@(posedge clk)
    (past_valid && !reset && !load) |=> (count == WIDTH'($past(count) + WIDTH'(1))));

  // All-ones rolls over to zero with no stall.
  a_wrap : assert property (@(posedge clk)
    (past_valid && !reset && !load && (count == '1)) |=> (count == '0));
`endif

endmodule : binary_up_counter4

// File: tb/tb_binary_up_counter4.sv
// Scoreboarded bench for the loadable up-counter at widths 4 and 8.
// Driver changes inputs on falling edges and queues the expected next counts.
// Monitor pops one entry per rising edge and compares both counter instances.
module tb_binary_up_counter4;

  typedef struct {
    int e4;
    int e8;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       load;
  logic [3:0] data4;
  logic [7:0] data8;
  logic [3:0] count4;
  logic [7:0] count8;

  exp_t q[$];
  int   total;
  int   bad;
  int   m4;
  int   m8;
  int   step_no;
  bit   done;

  binary_up_counter4 #(.WIDTH(4)) dut4 (
    .data_in (data4),
    .load    (load),
    .clk     (clk),
    .reset   (reset),
    .count   (count4)
  );

  binary_up_counter4 #(.WIDTH(8)) dut8 (
    .data_in (data8),
    .load    (load),
    .clk     (clk),
    .reset   (reset),
    .count   (count8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour: next value of a modulo-2^w counter.
  function automatic int model_next(input int cur, input bit r, input bit l,
                                    input int d, input int w);
    int modulus;
    modulus = 1 << w;
    if (r)      return 0;
    else if (l) return d % modulus;
    else        return (cur + 1) % modulus;
  endfunction

  // Drive one cycle of stimulus on the falling edge and queue what must follow.
  task automatic step(input bit r, input bit l, input int d4, input int d8);
    exp_t e;
    @(negedge clk);
    reset = r;
    load  = l;
    data4 = d4[3:0];
    data8 = d8[7:0];
    m4 = model_next(m4, r, l, d4, 4);
    m8 = model_next(m8, r, l, d8, 8);
    e.e4 = m4;
    e.e8 = m8;
    q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per rising edge once stimulus runs.
  initial begin
    exp_t e;
    step_no = 0;
    while (!done) begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        step_no++;
        total++;
        if (count4 !== e.e4[3:0]) begin
          bad++;
          $display("FAIL count4 edge %0d: got %0d want %0d", step_no, count4, e.e4);
        end
        total++;
        if (count8 !== e.e8[7:0]) begin
          bad++;
          $display("FAIL count8 edge %0d: got %0d want %0d", step_no, count8, e.e8);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    m4    = 0;
    m8    = 0;
    done  = 1'b0;
    reset = 1'b0;
    load  = 1'b0;
    data4 = '0;
    data8 = '0;

    // Reset, then count 1, 2, 3.
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // Reset then 20 free-running edges: 1..15, wrap, 0..4 on the 4-bit counter.
    step(1, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0);

    // Single-cycle preload then count on; the 8-bit counter wraps 255 -> 0.
    step(0, 1, 13, 254);
    repeat (4) step(0, 0, 0, 0);

    // Load held for three edges, then released.
    repeat (3) step(0, 1, 7, 7);
    step(0, 0, 0, 0);

    // Reset and load on the same edge.
    step(1, 1, 9, 9);

    // Reset mid-count at 5, then resume.
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0);

    // Randomised traffic: occasional resets, frequent loads, otherwise counting.
    for (int i = 0; i < 400; i++) begin
      bit r;
      bit l;
      r = ($urandom_range(0, 19) == 0);
      l = ($urandom_range(0, 4) == 0);
      step(r, l, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    end

    // Let the monitor drain, then confirm every queued expectation was checked.
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    done = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_binary_up_counter4
